simon_sequencer: RTL and testbench
==================================

# simon_sequencer

Game-round controller for the memory game. Owns the pattern memory and the round state machine. Sequences the shared 25-bit interval timer through its enable and clear inputs, and consumes the timer's one-cycle tick. Drives the LEDs to play back the pattern, checks the player's button presses, and reports win, lose and level to the display logic.

## Interface
- MAX_LEN, 16: rounds needed to win; legal range 2..31.
- TIMEOUT_TICKS, 8: ticks allowed between presses in the input phase before a loss; legal range 1..15.
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; starts a new game from IDLE, WIN or LOSE
- btn  input  4  debounced one-cycle press pulses, one bit per colour
- tick  input  1  one-cycle pulse from the interval timer
- tmr_en  output  1  interval timer enable
- tmr_clr  output  1  one-cycle synchronous clear to the interval timer
- led  output  4  one-hot colour display
- level  output  5  current pattern length
- busy  output  1  high in all states except IDLE, WIN and LOSE
- win  output  1  sticky; high in WIN
- lose  output  1  sticky; high in LOSE

## Operation
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
- Pattern memory: MAX_LEN × 2-bit registers. Colour c is displayed as led[c].
- IDLE:
  - led=0, tmr_en=0.
  - start → len=0, then ADD.
- ADD (1 cycle):
  - pattern[len] ← lfsr[1:0]; len ← len+1; idx ← 0.
  - Pulses tmr_clr. → SHOW_ON.
- SHOW_ON:
  - led=onehot(pattern[idx]), tmr_en=1.
  - tick → SHOW_OFF, with a tmr_clr pulse.
- SHOW_OFF:
  - led=0, tmr_en=1.
  - On tick with idx==len-1: idx ← 0, to_cnt ← 0, tmr_clr pulse → INPUT.
  - On tick otherwise: idx++, tmr_clr pulse → SHOW_ON.
- INPUT:
  - led=btn (echo), tmr_en=1.
  - A press is btn≠0.
  - Exactly one bit set and it equals onehot(pattern[idx]):
    - idx==len-1 and len==MAX_LEN → WIN.
    - idx==len-1 otherwise → ADD.
    - else idx++, to_cnt ← 0, tmr_clr pulse.
  - Any other non-zero btn (wrong colour or multi-hot) → LOSE.
  - With no press, each tick increments to_cnt; the tick that makes to_cnt==TIMEOUT_TICKS → LOSE.
- WIN:
  - led=4'b1111, tmr_en=0.
- LOSE:
  - led toggles between 4'b1111 and 0 on each tick, tmr_en=1.
- From WIN or LOSE, start → len=0, win=lose=0, then ADD.
- start while busy is ignored.
- btn outside INPUT is ignored.
- A press and a tick in the same INPUT cycle: the press wins and the tick is discarded.
- LFSR: 16-bit Fibonacci, next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, seed 16'hACE1, never zero.
- level = len. Width is 5 bits, with no wrap because MAX_LEN ≤ 31.

## Timing
- Reset values: state=IDLE, led=0, level=0, busy=0, win=0, lose=0, tmr_en=0, tmr_clr=0, lfsr=16'hACE1, pattern regs = 0.
- All outputs are registered or decoded from registered state; no combinational path from btn to any output except led in INPUT.
- tmr_clr is a single-cycle pulse on every entry to SHOW_ON, SHOW_OFF and INPUT, and after every accepted press.
- A tick coincident with tmr_clr is ignored.
- Latency: start → ADD next cycle → first LED on 2 cycles after start.
- Each LED is on for exactly one timer period and off for one period.
- Asserting reset mid-round returns to IDLE immediately and discards the pattern.

## Configuration
- SIMON_FIXED_SEED_EN:
  - Defined: the LFSR steps only in ADD, so the pattern is deterministic from reset: colours 1, 3, ...
  - Undefined: the LFSR free-runs every clock, so the pattern depends on start and press timing.

## Structure
- simon_pkg holds:
  - the state enum;
  - LFSR seed 16'hACE1 and the tap positions;
  - the colour-to-one-hot function;
  - the LED blink constants.
- Sub-module simon_lfsr: 16-bit LFSR with a step-enable input. Stepping is tied high or to the ADD state depending on the macro.
- The interval timer stays external; this block only drives its enable and clear.

## Test plan
- reset held then released, start pulsed (fixed seed) → level=1, led=4'b0010 for one tick period, then 0, then INPUT with busy=1.
- Round 1 answered with btn=4'b0010 → ADD; round 2 plays led 4'b0010 then 4'b1000; level=2.
- Round 2 correct first press, then btn=4'b0001 → LOSE, lose=1, busy=0, led blinks on ticks.
- INPUT with no press for 8 ticks → lose asserts on the 8th tick, not the 7th.
- MAX_LEN=2, both rounds correct → win=1, led=4'b1111; start → win=0, level=1.
- btn=4'b0011 in INPUT → LOSE; reset asserted during SHOW_ON → all outputs reset values within the same cycle.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding, LFSR constants and LED helpers for the Simon game
package simon_pkg;
  typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;
  localparam logic [3:0] LED_ALL = 4'b1111;
  localparam logic [3:0] LED_OFF = 4'b0000;
  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: 16-bit Fibonacci LFSR with step enable, exposes the low two bits as a colour
module simon_lfsr import simon_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] colour
);
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= LFSR_SEED;
    else if (en) lfsr <= {lfsr[14:0], lfsr[TAP_A] ^ lfsr[TAP_B] ^ lfsr[TAP_C] ^ lfsr[TAP_D]};
  assign colour = lfsr[1:0];
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon round controller; SIMON_FIXED_SEED_EN makes the LFSR step only in ADD
module simon_sequencer import simon_pkg::*; #(
  parameter int MAX_LEN       = 16,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       tick,
  output logic       tmr_en,
  output logic       tmr_clr,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);
  localparam int IW = $clog2(MAX_LEN);
  state_t     state;
  logic [1:0] pattern [MAX_LEN];
  logic [4:0] len, idx;
  logic [3:0] to_cnt;
  logic       blink, tk, last, lfsr_en;
  logic [1:0] colour;
  logic [3:0] want;
`ifdef SIMON_FIXED_SEED_EN
  assign lfsr_en = state == ADD;
`else
  assign lfsr_en = 1'b1;
`endif
  simon_lfsr u_lfsr (.clk(clk), .reset(reset), .en(lfsr_en), .colour(colour));
  always_comb begin
    want   = onehot(pattern[idx[IW-1:0]]);
    last   = idx == len - 5'd1;
    tk     = tick & ~tmr_clr;
    busy   = !(state inside {IDLE, WIN, LOSE});
    win    = state == WIN;
    lose   = state == LOSE;
    tmr_en = state inside {SHOW_ON, SHOW_OFF, INPUT, LOSE};
    level  = len;
    led    = state == SHOW_ON ? want :
             state == INPUT ? btn :
             (state == WIN || (state == LOSE && blink)) ? LED_ALL : LED_OFF;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      len     <= '0;
      idx     <= '0;
      to_cnt  <= '0;
      blink   <= 1'b0;
      tmr_clr <= 1'b0;
      pattern <= '{default: '0};
    end else begin
      tmr_clr <= 1'b0;
      case (state)
        IDLE, WIN, LOSE: begin
          if (state == LOSE && tk) blink <= ~blink;
          if (start) begin
            state <= ADD;
            len   <= '0;
          end
        end
        ADD: begin
          pattern[len[IW-1:0]] <= colour;
          len     <= len + 5'd1;
          idx     <= '0;
          tmr_clr <= 1'b1;
          state   <= SHOW_ON;
        end
        SHOW_ON: if (tk) begin
          state   <= SHOW_OFF;
          tmr_clr <= 1'b1;
        end
        SHOW_OFF: if (tk) begin
          tmr_clr <= 1'b1;
          idx     <= last ? 5'd0 : idx + 5'd1;
          to_cnt  <= '0;
          state   <= last ? INPUT : SHOW_ON;
        end
        INPUT:
          // a press takes priority over a coincident tick
          if (btn != LED_OFF) begin
            if (btn != want) begin
              state <= LOSE;
              blink <= 1'b1;
            end else if (!last) begin
              idx     <= idx + 5'd1;
              to_cnt  <= '0;
              tmr_clr <= 1'b1;
            end else state <= len == 5'(MAX_LEN) ? WIN : ADD;
          end else if (tk) begin
            to_cnt <= to_cnt + 4'd1;
            if (to_cnt == 4'(TIMEOUT_TICKS - 1)) begin
              state <= LOSE;
              blink <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: plays random games against a timeline model of the round controller
module tb_simon_sequencer;
  localparam int ML = 4;
  localparam int TO = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, add_now = 1'b0;
  logic [3:0] btn = '0;
  logic tick, tmr_en, tmr_clr, busy, win, lose;
  logic [3:0] led, tcnt;
  logic [4:0] level;
  logic [15:0] m_lfsr;
  logic [1:0] pat [$];
  int tests = 0, fails = 0, per = 3;

  simon_sequencer #(.MAX_LEN(ML), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .tick(tick),
    .tmr_en(tmr_en), .tmr_clr(tmr_clr), .led(led), .level(level),
    .busy(busy), .win(win), .lose(lose));

  always #5 clk = ~clk;

  // environment interval timer: ticks every per cycles after a clear
  always @(posedge clk or posedge reset)
    if (reset) tcnt <= '0;
    else if (tmr_clr) tcnt <= '0;
    else if (tmr_en) tcnt <= (tcnt == 4'(per - 1)) ? 4'd0 : tcnt + 4'd1;
  assign tick = tmr_en && !tmr_clr && tcnt == 4'(per - 1);

  function automatic logic [15:0] nx(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
`ifdef SIMON_FIXED_SEED_EN
    else if (add_now) m_lfsr <= nx(m_lfsr);
`else
    else m_lfsr <= nx(m_lfsr);
`endif

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic s, input logic a);
    @(negedge clk);
    btn = b;
    start = s;
    add_now = a;
    #1;
  endtask

  task automatic outs(input string ph, input logic [3:0] l, input logic b, input logic w,
                      input logic lo, input logic [4:0] lv);
    check({ph, ".led"}, 16'(led), 16'(l));
    check({ph, ".busy"}, 16'(busy), 16'(b));
    check({ph, ".win"}, 16'(win), 16'(w));
    check({ph, ".lose"}, 16'(lose), 16'(lo));
    check({ph, ".level"}, 16'(level), 16'(lv));
  endtask

  task automatic blink_run(input logic [4:0] lv);
    logic bl;
    bl = 1'b1;
    for (int k = 0; k < 3 * per + 2; k++) begin
      if (tick) bl = ~bl;
      step(4'($urandom), 1'b0, 1'b0);
      outs("lose", {4{bl}}, 1'b0, 1'b0, 1'b1, lv);
      check("lose.en", 16'(tmr_en), 16'd1);
    end
  endtask

  // mode 0: win, 1: wrong colour, 2: multi-hot press, 3: timeout
  task automatic play(input int mode);
    int fr, fp, d, n, t;
    logic [3:0] b, good;
    logic [1:0] c;
    per = $urandom_range(2, 4);
    fr = $urandom_range(ML - 1);
    fp = $urandom_range(fr);
    pat.delete();
    step(4'($urandom), 1'b1, 1'b0);
    for (int r = 0; r < ML; r++) begin
      step(4'd0, 1'b0, 1'b1);
      outs("add", 4'd0, 1'b1, 1'b0, 1'b0, 5'(r));
      check("add.clr", 16'(tmr_clr), 16'd0);
      pat.push_back(m_lfsr[1:0]);
      for (int i = 0; i <= r; i++) begin
        for (int k = 0; k <= per; k++) begin
          step(4'($urandom), $urandom_range(7) == 0, 1'b0);
          outs("on", 4'b1 << pat[i], 1'b1, 1'b0, 1'b0, 5'(r + 1));
          check("on.clr", 16'(tmr_clr), 16'(k == 0));
          check("on.en", 16'(tmr_en), 16'd1);
        end
        for (int k = 0; k <= per; k++) begin
          step(4'($urandom), $urandom_range(7) == 0, 1'b0);
          outs("off", 4'd0, 1'b1, 1'b0, 1'b0, 5'(r + 1));
          check("off.clr", 16'(tmr_clr), 16'(k == 0));
        end
      end
      for (int i = 0; i <= r; i++) begin
        good = 4'b1 << pat[i];
        if (mode == 3 && r == fr && i == fp) begin
          n = 0;
          t = 0;
          while (n < TO && t < TO * per + 5) begin
            step(4'd0, 1'b0, 1'b0);
            check("to.lose", 16'(lose), 16'd0);
            check("to.clr", 16'(tmr_clr), 16'(t == 0));
            if (tick) n++;
            t++;
          end
          check("to.cycles", 16'(t), 16'(TO * per + 1));
          step(4'd0, 1'b0, 1'b0);
          outs("to.end", 4'hF, 1'b0, 1'b0, 1'b1, 5'(r + 1));
          blink_run(5'(r + 1));
          return;
        end
        d = $urandom_range(TO * per);
        for (int k = 0; k < d; k++) begin
          step(4'd0, 1'b0, 1'b0);
          outs("wait", 4'd0, 1'b1, 1'b0, 1'b0, 5'(r + 1));
          check("wait.clr", 16'(tmr_clr), 16'(k == 0));
        end
        c = 2'(pat[i] + 2'($urandom_range(1, 3)));
        b = good;
        if ((mode == 1 || mode == 2) && r == fr && i == fp)
          b = mode == 1 ? 4'b1 << c : good | (4'b1 << c) | 4'($urandom);
        step(b, 1'b0, 1'b0);
        outs("press", b, 1'b1, 1'b0, 1'b0, 5'(r + 1));
        check("press.clr", 16'(tmr_clr), 16'(d == 0));
        if (b != good) begin
          step(4'd0, 1'b0, 1'b0);
          outs("bad", 4'hF, 1'b0, 1'b0, 1'b1, 5'(r + 1));
          check("bad.en", 16'(tmr_en), 16'd1);
          blink_run(5'(r + 1));
          return;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(4'($urandom), 1'b0, 1'b0);
      outs("win", 4'hF, 1'b0, 1'b1, 1'b0, 5'(ML));
      check("win.en", 16'(tmr_en), 16'd0);
    end
  endtask

  task automatic idle_outs(input string ph);
    outs(ph, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    check({ph, ".en"}, 16'(tmr_en), 16'd0);
    check({ph, ".clr"}, 16'(tmr_clr), 16'd0);
  endtask

  task automatic reset_mid();
    logic [1:0] c0;
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b1);
    c0 = m_lfsr[1:0];
    repeat ($urandom_range(1, per + 1)) step(4'd0, 1'b0, 1'b0);
    check("rm.on", 16'(led), 16'(4'b1 << c0));
    #1 reset = 1'b1;
    #1 idle_outs("rm.rst");
    @(negedge clk);
    reset = 1'b0;
    step(4'($urandom), 1'b0, 1'b0);
    idle_outs("rm.idle");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 idle_outs("reset");
    @(negedge clk);
    reset = 1'b0;
    step(4'($urandom), 1'b0, 1'b0);
    idle_outs("idle");
    play(0);
    for (int g = 0; g < 12; g++) begin
      if (g % 5 == 2) reset_mid();
      play(g % 4);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
